// File: rtl/zjh_scan_ctrl_if.sv
// Bus bundle for the 4-digit 7-segment scan controller: control inputs,
// shadow-register write port, digit selects, segment drives and status.
interface zjh_scan_ctrl_if;
    logic       enable;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       lz_en;
    logic       Y1, Y2, Y3, Y4;
    logic       a, b, c, d, e, f, g;
    logic [1:0] dig_idx;
    logic       frame_done;

    modport master (
        output enable, wr_en, wr_addr, wr_data, lz_en,
        input  Y1, Y2, Y3, Y4, a, b, c, d, e, f, g, dig_idx, frame_done
    );

    modport slave (
        input  enable, wr_en, wr_addr, wr_data, lz_en,
        output Y1, Y2, Y3, Y4, a, b, c, d, e, f, g, dig_idx, frame_done
    );
endinterface

// File: rtl/zjh_scan_ctrl.sv
// Multiplexed 4-digit hex display scanner. Each digit is driven for
// SCAN_DIV cycles followed by one blank anti-ghosting cycle. Writes land in
// a shadow bank that is copied to the display bank only at frame boundaries
// so a frame never shows a mix of old and new values.
module zjh_scan_ctrl #(
    parameter int SCAN_DIV = 4
) (
    input logic         Clock,
    input logic         Aclr,
    zjh_scan_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

    localparam logic [15:0] LAST = 16'(SCAN_DIV - 1);

    state_t          state;
    logic [15:0]     cnt;
    logic [1:0]      idx;
    logic [3:0][3:0] shadow;
    logic [3:0][3:0] shadow_nx;
    logic [3:0][3:0] disp;
    logic [3:0]      ysel;
    logic [6:0]      seg;
    logic            fdone;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1111110;
            4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;
            4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;
            4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;
            4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;
            4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;
            4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;
            default: return 7'b1000111;
        endcase
    endfunction

    // Leading-zero blanking: a digit goes dark only if it and every digit
    // to its left are zero; the rightmost digit always shows.
    function automatic logic [6:0] digit_seg(input logic [3:0][3:0] vals,
                                             input logic [1:0] i,
                                             input logic lz);
        logic blank;
        blank = 1'b0;
        if (lz) begin
            case (i)
                2'd3:    blank = (vals[3] == 4'h0);
                2'd2:    blank = (vals[3] == 4'h0) && (vals[2] == 4'h0);
                2'd1:    blank = (vals[3] == 4'h0) && (vals[2] == 4'h0) && (vals[1] == 4'h0);
                default: blank = 1'b0;
            endcase
        end
        return blank ? 7'b0000000 : hex7(vals[i]);
    endfunction

    function automatic logic [3:0] sel_of(input logic [1:0] i);
        return ~(4'b0001 << i);
    endfunction

    // Shadow bank including this cycle's write, so a copy on the same edge sees it.
    always_comb begin
        shadow_nx = shadow;
        if (bus.wr_en) shadow_nx[bus.wr_addr] = bus.wr_data;
    end

    // Scan FSM; outputs are registered against the state being entered.
    always_ff @(posedge Clock) begin
        if (Aclr) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            shadow <= '0;
            disp   <= '0;
            ysel   <= 4'hF;
            seg    <= '0;
            fdone  <= 1'b0;
        end else begin
            shadow <= shadow_nx;
            fdone  <= 1'b0;
            if (!bus.enable) begin
                state <= IDLE;
                cnt   <= '0;
                idx   <= '0;
                ysel  <= 4'hF;
                seg   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= SHOW;
                        cnt   <= '0;
                        idx   <= '0;
                        disp  <= shadow_nx;
                        ysel  <= sel_of(2'd0);
                        seg   <= digit_seg(shadow_nx, 2'd0, bus.lz_en);
                    end
                    SHOW: begin
                        if (cnt == LAST) begin
                            state <= GAP;
                            ysel  <= 4'hF;
                            seg   <= '0;
                            fdone <= (idx == 2'd3);
                        end else begin
                            cnt <= cnt + 16'd1;
                            seg <= digit_seg(disp, idx, bus.lz_en);
                        end
                    end
                    GAP: begin
                        state <= SHOW;
                        cnt   <= '0;
                        idx   <= idx + 2'd1;
                        ysel  <= sel_of(idx + 2'd1);
                        if (fdone) begin
                            disp <= shadow_nx;
                            seg  <= digit_seg(shadow_nx, idx + 2'd1, bus.lz_en);
                        end else begin
                            seg  <= digit_seg(disp, idx + 2'd1, bus.lz_en);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.Y1 = ysel[0];
    assign bus.Y2 = ysel[1];
    assign bus.Y3 = ysel[2];
    assign bus.Y4 = ysel[3];
    assign {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g} = seg;
    assign bus.dig_idx    = idx;
    assign bus.frame_done = fdone;

endmodule

// File: tb/tb_zjh_scan_ctrl.sv
// Directed bench for zjh_scan_ctrl with SCAN_DIV=4 (20-cycle frames).
module tb_zjh_scan_ctrl;

    logic Clock;
    logic Aclr;
    int   ncmp;
    int   nerr;

    zjh_scan_ctrl_if bus ();

    zjh_scan_ctrl #(.SCAN_DIV(4)) dut (
        .Clock (Clock),
        .Aclr  (Aclr),
        .bus   (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    localparam logic [6:0] S0 = 7'b1111110;
    localparam logic [6:0] S1 = 7'b0110000;
    localparam logic [6:0] S2 = 7'b1101101;
    localparam logic [6:0] S3 = 7'b1111001;
    localparam logic [6:0] S4 = 7'b0110011;
    localparam logic [6:0] S5 = 7'b1011011;
    localparam logic [6:0] SF = 7'b1000111;
    localparam logic [6:0] BL = 7'b0000000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {Y4,Y3,Y2,Y1,a..g}
    function automatic logic [10:0] obs();
        return {bus.Y4, bus.Y3, bus.Y2, bus.Y1,
                bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g};
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // One full frame starting at the edge that enters SHOW of digit 0.
    // exps[i] = expected segments on digit i. When ws>0, writes addr 0..3
    // with wvals[0..3] are presented after cycles ws..ws+3.
    task automatic run_frame(input string name, input logic [3:0][6:0] exps,
                             input int ws, input logic [3:0][3:0] wvals);
        int dig, pos;
        logic [3:0] ys;
        logic [6:0] sg;
        for (int t = 1; t <= 20; t++) begin
            tick();
            bus.wr_en = 1'b0;
            if (ws > 0 && t >= ws && t < ws + 4) begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = 2'(t - ws);
                bus.wr_data = wvals[t - ws];
            end
            dig = (t - 1) / 5;
            pos = (t - 1) % 5;
            if (pos < 4) begin
                ys = ~(4'b0001 << dig);
                sg = exps[dig];
            end else begin
                ys = 4'hF;
                sg = BL;
            end
            chk($sformatf("%s_out_c%0d", name, t), 32'(obs()), 32'({ys, sg}));
            chk($sformatf("%s_idx_c%0d", name, t), 32'(bus.dig_idx), 32'(dig));
            chk($sformatf("%s_fd_c%0d", name, t), 32'(bus.frame_done), 32'(t == 20));
        end
    endtask

    initial begin
        int fd_seen;
        ncmp = 0;
        nerr = 0;
        Aclr = 1'b1;
        bus.enable  = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = 2'd0;
        bus.wr_data = 4'h0;
        bus.lz_en   = 1'b0;

        // reset state, with enable and a write asserted to prove reset wins
        tick();
        bus.enable  = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 2'd2;
        bus.wr_data = 4'h9;
        tick();
        chk("rst_out", 32'(obs()), 32'({4'hF, BL}));
        chk("rst_idx", 32'(bus.dig_idx), 32'd0);
        chk("rst_fd", 32'(bus.frame_done), 32'd0);
        bus.wr_en = 1'b0;
        Aclr = 1'b0;

        // plain scan of zeros; writes 1..4 land mid-frame and stay hidden
        run_frame("f1", {S0, S0, S0, S0}, 6, {4'h4, 4'h3, 4'h2, 4'h1});
        // new values appear; arm leading-zero blanking and write 0,0,5,0
        bus.lz_en = 1'b1;
        run_frame("f2", {S4, S3, S2, S1}, 2, {4'h0, 4'h0, 4'h5, 4'h0});
        run_frame("f3", {BL, BL, S5, S0}, 0, 16'h0);

        // write in the frame_done cycle is included in the copy
        bus.wr_en   = 1'b1;
        bus.wr_addr = 2'd2;
        bus.wr_data = 4'hF;
        run_frame("f4", {BL, SF, S5, S0}, 0, 16'h0);

        // drop enable during SHOW of digit 2
        for (int t = 1; t <= 11; t++) tick();
        chk("ab_pre", 32'(obs()), 32'({4'b1011, SF}));
        bus.enable = 1'b0;
        tick();
        chk("ab_out", 32'(obs()), 32'({4'hF, BL}));
        chk("ab_idx", 32'(bus.dig_idx), 32'd0);
        fd_seen = 0;
        for (int t = 0; t < 12; t++) begin
            if (bus.frame_done) fd_seen++;
            tick();
        end
        chk("ab_nofd", 32'(fd_seen), 32'd0);
        bus.enable = 1'b1;
        run_frame("f5", {BL, SF, S5, S0}, 0, 16'h0);

        // reset mid-SHOW with pending writes
        bus.lz_en = 1'b0;
        tick();
        bus.wr_en   = 1'b1;
        bus.wr_addr = 2'd1;
        bus.wr_data = 4'h7;
        tick();
        bus.wr_addr = 2'd3;
        bus.wr_data = 4'h9;
        Aclr = 1'b1;
        tick();
        chk("mr_out", 32'(obs()), 32'({4'hF, BL}));
        chk("mr_fd", 32'(bus.frame_done), 32'd0);
        bus.wr_en = 1'b0;
        Aclr = 1'b0;
        run_frame("f6", {S0, S0, S0, S0}, 0, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/zjh_scan_ctrl.md
ZJH_SCAN_CTRL -- requirements
Module: zjh_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 4, Clock cycles each digit is driven per visit; legal range 2..65535.
REQ-002 Clock  input  1  single system clock; all state updates on rising edge.
REQ-003 Aclr  input  1  reset, synchronous and active-high.
REQ-004 enable  input  1  high = scanning runs; low = display dark.
REQ-005 wr_en  input  1  one-cycle write strobe into the shadow digit register.
REQ-006 wr_addr  input  2  shadow register index 0..3 (0 = rightmost digit, driven by Y1).
REQ-007 wr_data  input  4  hex value 0..F to store.
REQ-008 lz_en  input  1  high = leading-zero suppression on.
REQ-009 Y1, Y2, Y3, Y4  output  1 each  active-low digit selects for digit index 0, 1, 2, 3; at most one low at any time.
REQ-010 a, b, c, d, e, f, g  output  1 each  active-high segment drives.
REQ-011 dig_idx  output  2  index of the digit currently selected or last selected.
REQ-012 frame_done  output  1  one-cycle pulse at end of each full 4-digit scan.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHOW and GAP.
REQ-014 IDLE: Y1..Y4 = 1, a..g = 0; when enable = 1, the next state SHALL be SHOW with dig_idx = 0 and the cycle counter cleared.
REQ-015 SHOW SHALL last exactly SCAN_DIV cycles.
  - the selected Y SHALL be low
  - segments SHALL show the decoded display value of digit dig_idx
  - SHOW SHALL then go to GAP.
REQ-016 GAP SHALL last exactly 1 cycle with Y1..Y4 = 1 and a..g = 0 (anti-ghosting).
  - on GAP exit, dig_idx SHALL increment modulo 4 and the FSM SHALL go to SHOW.
REQ-017 One digit period = SCAN_DIV+1 cycles; one frame = 4*(SCAN_DIV+1) cycles.
REQ-018 frame_done SHALL be high exactly in the GAP cycle that follows digit 3.
REQ-019 If enable = 0 in any state, the next state SHALL be IDLE, dig_idx SHALL be 0 and the counter cleared.
  - frame_done SHALL NOT pulse for an aborted frame.
REQ-020 Every wr_en cycle SHALL update shadow[wr_addr] with wr_data at the next edge; back-to-back writes SHALL all be accepted.
REQ-021 Shadow registers SHALL copy into the display registers only on the edge ending a frame_done cycle, and on the IDLE->SHOW transition.
  - a write in that same cycle SHALL be included in the copy.
  - no display value SHALL change mid-frame.
REQ-022 Hex decode (segments a..g, 1 = on):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
REQ-023 With lz_en = 1:
  - digit 3 SHALL be blanked if its display value = 0
  - digit 2 SHALL be blanked if digits 3 and 2 = 0
  - digit 1 SHALL be blanked if digits 3..1 = 0
  - digit 0 SHALL never be blanked.
REQ-024 A blanked digit SHALL still assert its Y low for SHOW timing, with a..g = 0.
REQ-025 lz_en changes SHALL take effect from the next SHOW cycle (no frame-boundary sync).
REQ-026 All outputs SHALL be registered; an output change SHALL appear at the edge that enters the corresponding state.

Reset
REQ-027 While Aclr = 1 at an edge, the following SHALL be cleared: state=IDLE, counter=0, dig_idx=0, shadow and display registers=0, Y1..Y4=1, a..g=0, frame_done=0.
REQ-028 Aclr SHALL override enable and wr_en in the same cycle.
REQ-029 Aclr asserted mid-frame SHALL abort the scan with no frame_done pulse.
REQ-030 After Aclr drops with enable = 1, the first SHOW of digit 0 SHALL begin one cycle later.

Verification
REQ-031 SCAN_DIV=4, enable=1 after reset:
  - Y1 low for 4 cycles, then 1 GAP cycle, then Y2, Y3, Y4 in turn
  - frame_done at cycle 20 of each frame
  - never two Y low at once.
REQ-032 Write 1,2,3,4 to addr 0..3 mid-frame:
  - segments unchanged until frame_done
  - next frame shows 0110000, 1101101, 1111001, 0110011 on Y1..Y4.
REQ-033 Display 0,0,5,0 (addr 3..0), lz_en=1:
  - Y4 slot a..g=0
  - Y3 slot a..g=0
  - Y2 slot 1011011
  - Y1 slot 1111110.
REQ-034 Write addr 2 = F in the frame_done cycle -> the next frame shows 1000111 on Y3.
REQ-035 enable dropped during SHOW of digit 2:
  - next cycle IDLE, all Y=1, no frame_done
  - re-enable -> digit 0 first.
REQ-036 Aclr pulsed mid-SHOW with pending shadow writes:
  - next edge gives all Y=1, a..g=0
  - after release, all digits display 0 (1111110).
